// File: rtl/status_uart_tx.sv
// Status reporter: sends {2'b10, 2'b00, motor, gray} as one 8N1 UART frame whenever
// the zone/motor status changes or a send is forced. Changes seen mid-frame merge into one follow-up frame.
module status_uart_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] gray_code,
  input  logic       motor_sig,
  input  logic       force_send,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frames_sent
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_baud_cnt, w_baud_nxt;
  logic [2:0]    r_bit_cnt, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic [7:0]    r_frames, w_frames_nxt;
  logic          r_pending, w_pending_nxt;
  logic [3:0]    r_prev_status;

  logic [3:0]    w_status;
  logic          w_event;
  logic          w_last;

  assign w_status = {motor_sig, gray_code};
  assign w_event  = (w_status != r_prev_status) || force_send;
  assign w_last   = (r_baud_cnt == LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud_cnt;
    w_bit_nxt     = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = r_tx;
    w_frames_nxt  = r_frames;
    w_pending_nxt = r_pending | w_event;
    if (r_state != S_IDLE) w_baud_nxt = w_last ? '0 : r_baud_cnt + 1'b1;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        if (r_pending) begin
          // an event in this same cycle keeps pending set for a follow-up frame
          w_pending_nxt = w_event;
          w_shift_nxt   = {4'b1000, w_status};
          w_state_nxt   = S_START;
          w_tx_nxt      = 1'b0;
        end
      end
      S_START: begin
        if (w_last) begin
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_last) begin
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit_cnt + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_last) begin
          w_state_nxt  = S_IDLE;
          w_frames_nxt = r_frames + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_baud_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_tx          <= 1'b1;
      r_frames      <= '0;
      r_pending     <= 1'b0;
      r_prev_status <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_baud_cnt    <= w_baud_nxt;
      r_bit_cnt     <= w_bit_nxt;
      r_shift       <= w_shift_nxt;
      r_tx          <= w_tx_nxt;
      r_frames      <= w_frames_nxt;
      r_pending     <= w_pending_nxt;
      r_prev_status <= w_status;
    end
  end

  assign tx          = r_tx;
  assign busy        = (r_state != S_IDLE);
  assign frames_sent = r_frames;

endmodule

// File: tb/tb_status_uart_tx.sv
// Bench for status_uart_tx: a line monitor decodes every frame cycle by cycle and
// compares it against a queue of expected bytes; directed sequences cover timing corners.
`timescale 1ns/1ps
module tb_status_uart_tx;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] gray_code = 3'b000;
  logic       motor_sig = 1'b0;
  logic       force_send = 1'b0;
  logic       tx, busy;
  logic [7:0] frames_sent;

  int         n_chk = 0;
  int         n_err = 0;
  int         exp_frames;
  logic [7:0] sb[$];

  typedef struct {
    logic [2:0] gray;
    logic       motor;
    logic       frc;
    logic [7:0] exp_byte;
  } vec_t;
  vec_t vecs[8];

  status_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .gray_code(gray_code), .motor_sig(motor_sig),
    .force_send(force_send), .tx(tx), .busy(busy), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line monitor: collects tx for every busy cycle, checks the whole 40-cycle waveform.
  initial begin : monitor
    int         cnt;
    logic [39:0] samp;
    logic [39:0] want;
    logic [7:0]  eb;
    cnt = 0;
    samp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
      end else if (busy) begin
        if (cnt < FRAME) samp[cnt] = tx;
        cnt++;
        if (cnt == FRAME) begin
          n_chk++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_frame: got frame %0h expected no frame", samp);
          end else begin
            eb = sb.pop_front();
            for (int k = 0; k < FRAME; k++) begin
              int b;
              b = k / CPB;
              want[k] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : eb[b-1];
            end
            if (samp !== want) begin
              n_err++;
              $display("FAIL frame_%0h: got waveform %0h expected %0h", eb, samp, want);
            end
          end
        end
      end else if (cnt != 0) begin
        chk("busy_len", cnt, FRAME);
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset(input logic [2:0] g, input logic m);
    @(negedge clk);
    rst_n = 1'b0;
    gray_code = g;
    motor_sig = m;
    force_send = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames_sent, 0);
    sb.delete();
    exp_frames = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int t;
    t = 0;
    while (busy !== lvl && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, busy, lvl);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk(name, sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    vecs[0] = '{3'b001, 1'b0, 1'b0, 8'h81};
    vecs[1] = '{3'b011, 1'b1, 1'b0, 8'h8B};
    vecs[2] = '{3'b111, 1'b0, 1'b0, 8'h87};
    vecs[3] = '{3'b101, 1'b1, 1'b0, 8'h8D};
    vecs[4] = '{3'b101, 1'b1, 1'b1, 8'h8D};
    vecs[5] = '{3'b100, 1'b0, 1'b0, 8'h84};
    vecs[6] = '{3'b110, 1'b1, 1'b0, 8'h8E};
    vecs[7] = '{3'b000, 1'b0, 1'b1, 8'h80};

    // nonzero status at reset release sends exactly one frame
    do_reset(3'b110, 1'b1);
    sb.push_back(8'h8E);
    wait_done("t1_drain");
    chk("t1_frames", frames_sent, 1);
    repeat (20) @(negedge clk);
    chk("t1_idle", {busy, tx}, 2'b01);
    chk("t1_frames_hold", frames_sent, 1);

    // all-zero status stays quiet; force_send starts the frame two cycles later
    do_reset(3'b000, 1'b0);
    repeat (10) @(negedge clk);
    chk("t2_quiet", {busy, tx}, 2'b01);
    force_send = 1'b1;
    sb.push_back(8'h80);
    @(negedge clk);
    force_send = 1'b0;
    chk("t2_pre", {busy, tx}, 2'b01);
    @(negedge clk);
    chk("t2_start", {busy, tx}, 2'b10);
    wait_done("t2_drain");
    chk("t2_frames", frames_sent, 1);

    exp_frames = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      gray_code  = vecs[i].gray;
      motor_sig  = vecs[i].motor;
      force_send = vecs[i].frc;
      sb.push_back(vecs[i].exp_byte);
      @(negedge clk);
      force_send = 1'b0;
      wait_done("vec_drain");
      exp_frames++;
      chk("vec_frames", frames_sent, exp_frames);
    end

    // several changes mid-frame coalesce into one follow-up frame after a 1-cycle gap
    do_reset(3'b001, 1'b0);
    sb.push_back(8'h81);
    wait_busy(1'b1, "t3_busy");
    repeat (5) @(negedge clk);
    gray_code = 3'b011;
    repeat (10) @(negedge clk);
    gray_code = 3'b010;
    sb.push_back(8'h82);
    wait_busy(1'b0, "t3_end");
    @(negedge clk);
    chk("t3_gap", {busy, tx}, 2'b10);
    wait_done("t3_drain");
    chk("t3_frames", frames_sent, 2);

    // reset in the middle of data bit 3 abandons the frame
    do_reset(3'b101, 1'b0);
    wait_busy(1'b1, "t4_busy");
    repeat (17) @(negedge clk);
    chk("t4_bit3", tx, 0);
    #2 rst_n = 1'b0;
    #1 chk("t4_async", {busy, tx}, 2'b01);
    chk("t4_frames", frames_sent, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(8'h85);
    wait_done("t4_drain");
    chk("t4_frames_after", frames_sent, 1);

    // frame counter wraps after 256 frames
    do_reset(3'b000, 1'b0);
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      force_send = 1'b1;
      sb.push_back(8'h80);
      @(negedge clk);
      force_send = 1'b0;
      wait_done("t5_drain");
      if (i == 255) chk("t5_frames_255", frames_sent, 255);
    end
    chk("t5_wrap", frames_sent, 0);

    // force_send in the cycle IDLE consumes pending: two identical frames
    sb.push_back(8'h8B);
    sb.push_back(8'h8B);
    @(negedge clk);
    gray_code = 3'b011;
    motor_sig = 1'b1;
    @(negedge clk);
    force_send = 1'b1;
    @(negedge clk);
    force_send = 1'b0;
    chk("t6_start", {busy, tx}, 2'b10);
    wait_busy(1'b0, "t6_end");
    @(negedge clk);
    chk("t6_gap", {busy, tx}, 2'b10);
    wait_done("t6_drain");
    chk("t6_frames", frames_sent, 2);

    repeat (30) @(negedge clk);
    chk("final_idle", {busy, tx}, 2'b01);
    chk("final_frames", frames_sent, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
